// File: rtl/fetch_unit.sv
// Instruction fetch stage: pipelined Avalon-MM word reads into a small FIFO toward decode.
// Optional perf counters are enabled with `define FETCH_PERF_COUNTERS_EN.
//
// state         | meaning
// RUN           | issue reads while FIFO + in-flight room remains
// WAIT_REDIRECT | PC write seen or flushed; no new reads until redirect_valid
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic        imem_readdatavalid,
  input  logic [31:0] imem_readdata,
  input  logic        hold,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  input  logic        is_pc_changing,
  input  logic        early_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  typedef enum logic {RUN = 1'b0, WAIT_REDIRECT = 1'b1} state_t;

  state_t          state, state_n;
  logic [31:0]     fetch_pc, fetch_pc_n, ret_pc, ret_pc_n, addr_hold;
  logic            pending, stale, stale_n;
  logic [CW-1:0]   outstanding, outstanding_n, discard, discard_n, count, count_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [31:0]     fifo_pc  [FIFO_DEPTH];
  logic [31:0]     fifo_ins [FIFO_DEPTH];
  logic            room, accept, push, pop, flush;

  // A request stalled by waitrequest stays on the bus even across a flush; it is then stale.
  assign room         = (({1'b0, outstanding} + {1'b0, count}) < DEPTH_C) && (outstanding < MAXO_C);
  assign imem_read    = reset_n && (pending || (state == RUN && room));
  assign imem_address = pending ? addr_hold : fetch_pc;
  assign accept       = imem_read && !imem_waitrequest;

  assign out_valid       = (count != '0);
  assign out_pc          = fifo_pc[rd_ptr];
  assign out_instruction = fifo_ins[rd_ptr];
  assign pop             = out_valid && !hold;

  assign flush = early_flush || (state == RUN && (redirect_valid || is_pc_changing));
  assign push  = imem_readdatavalid && (discard == '0) && !flush;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    ret_pc_n      = ret_pc;
    stale_n       = stale && !accept;
    outstanding_n = outstanding + CW'(accept) - CW'(imem_readdatavalid);
    discard_n     = discard - CW'(imem_readdatavalid && (discard != '0)) + CW'(accept && stale);
    count_n       = count + CW'(push) - CW'(pop);
    wr_ptr_n      = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_n      = pop ? rd_ptr + PW'(1) : rd_ptr;

    if (accept && !stale)
      fetch_pc_n = fetch_pc + 32'd4;
    if (push)
      ret_pc_n = ret_pc + 32'd4;

    // Everything in flight after this cycle belongs to the abandoned stream.
    if (flush) begin
      state_n   = WAIT_REDIRECT;
      discard_n = outstanding_n;
      count_n   = '0;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      if (imem_read && !accept)
        stale_n = 1'b1;
    end

    if (redirect_valid) begin
      state_n    = RUN;
      fetch_pc_n = redirect_pc & 32'hFFFF_FFFC;
      ret_pc_n   = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      addr_hold   <= RESET_PC;
      pending     <= 1'b0;
      stale       <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]  <= '0;
        fifo_ins[i] <= '0;
      end
    end else begin
      fetch_pc    <= fetch_pc_n;
      ret_pc      <= ret_pc_n;
      addr_hold   <= imem_address;
      pending     <= imem_read && imem_waitrequest;
      stale       <= stale_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      count       <= count_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      if (push) begin
        fifo_pc[wr_ptr]  <= ret_pc;
        fifo_ins[wr_ptr] <= imem_readdata;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched      <= '0;
      perf_discarded    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      if (imem_readdatavalid && !push)
        perf_discarded <= perf_discarded + 32'd1;
      if (state == WAIT_REDIRECT)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: variable-latency memory model plus an expected-PC scoreboard.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic        imem_readdatavalid;
  logic [31:0] imem_readdata;
  logic        hold;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        is_pc_changing;
  logic        early_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_discarded, perf_stall_cycles;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_waitrequest(imem_waitrequest), .imem_readdatavalid(imem_readdatavalid),
    .imem_readdata(imem_readdata), .hold(hold), .out_valid(out_valid),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .is_pc_changing(is_pc_changing), .early_flush(early_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc   = 0;
  int          lat   = 1;
  int          n_acc = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    hold = 1'b1;
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s_timeout observed_left=%0d expected_left=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Memory: accepts sampled mid-cycle, data returned in order after lat cycles.
  initial begin
    imem_readdatavalid = 1'b0;
    imem_readdata      = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (imem_read && !imem_waitrequest) begin
        pend_addr.push_back(imem_address);
        pend_due.push_back(cyc + lat);
        n_acc++;
      end
      @(posedge clock);
      cyc++;
      #1;
      if (reset_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_readdatavalid = 1'b1;
        imem_readdata      = instr_of(pend_addr.pop_front());
        pend_due.delete(0);
      end else begin
        imem_readdatavalid = 1'b0;
        imem_readdata      = '0;
      end
    end
  end

  // Decode-side scoreboard: each accepted word must be the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid && !hold) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_out observed_pc=%h expected=none", out_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_instruction", out_instruction, instr_of(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int k;
    reset_n = 1'b0; imem_waitrequest = 1'b0; hold = 1'b0; is_pc_changing = 1'b0;
    early_flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check("rst_imem_read", {31'b0, imem_read}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instruction", out_instruction, 32'd0);
    check("rst_imem_address", imem_address, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_discarded", perf_discarded, 32'd0);
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
`endif
    tick(); tick();
    reset_n = 1'b1;

    // Streaming from reset with a 3-cycle waitrequest at 0x10.
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    k = 0;
    while (!(imem_read && imem_address == 32'h10) && k < 40) begin
      tick();
      k++;
    end
    check("reach_addr_10", imem_address, 32'h10);
    imem_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wait_addr_held", imem_address, 32'h10);
      check("wait_read_held", {31'b0, imem_read}, 32'd1);
      tick();
      if (i == 2) imem_waitrequest = 1'b0;
    end
    @(negedge clock);
    check("addr_after_wait", imem_address, 32'h14);
    drain("stream", 100);

    // Hold for 10 cycles: head frozen, issue stops at the buffer cap.
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_pc", out_pc, 32'h40);
      tick();
    end
    @(negedge clock);
    check("hold_read_idle", {31'b0, imem_read}, 32'd0);
    n_checks++;
    assert (n_acc - acc0 <= 4) else begin
      n_err++;
      $error("FAIL hold_issue_cap observed=%0d expected<=4", n_acc - acc0);
    end
    tick();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + 32'(i * 4));
    hold = 1'b0;
    drain("after_hold", 60);

    // PC write at 0x20 with latency-3 memory, redirect five cycles later.
    lat = 3;
    early_flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    early_flush = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i <= 8; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    hold = 1'b0;
    k = 0;
    while (!(out_valid && out_pc == 32'h20) && k < 60) begin
      tick();
      k++;
    end
    check("reach_pc_20", out_pc, 32'h20);
    is_pc_changing = 1'b1;
    tick();
    is_pc_changing = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("wait_redirect_empty", {31'b0, out_valid}, 32'd0);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clock);
    check("wait_redirect_no_issue", {31'b0, imem_read}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    drain("redirect_100", 80);

    // Flush with redirect to the last word of the address space.
    lat = 1;
    early_flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    early_flush = 1'b0; redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    hold = 1'b0;
    drain("wrap", 40);

    // Reset mid-stream with two reads in flight.
    lat = 2;
    early_flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    early_flush = 1'b0; redirect_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("midrst_imem_read", {31'b0, imem_read}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_pc", out_pc, 32'd0);
    check("midrst_out_instruction", out_instruction, 32'd0);
    tick(); tick();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    reset_n = 1'b1;
    hold = 1'b0;
    drain("after_reset", 40);

    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
